// File: rtl/ppm_slot_modulator.sv
// 4-PPM slot modulator: one 2-bit symbol per handshake becomes a single pulse in slot 0..3, then guard slots.
// Optional feature: define PPM_PREAMBLE_EN to precede each burst from IDLE with a slot-0/slot-3 preamble frame.
module ppm_slot_modulator #(
  parameter int SLOT_CYCLES  = 4,
  parameter int PULSE_CYCLES = 2,
  parameter int GUARD_SLOTS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sym_in,
  input  logic       sym_valid,
  output logic       sym_ready,
  output logic       ppm_out,
  output logic       busy,
  output logic       sym_done
);

  localparam int NSLOTS = 4 + GUARD_SLOTS;
  localparam int CW     = $clog2(SLOT_CYCLES);
  localparam int SW     = $clog2(NSLOTS);

  localparam logic [CW-1:0] CYC_LAST   = CW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(NSLOTS - 1);
  localparam logic [SW-1:0] PRE_SLOT_B = SW'(3);
  localparam logic [CW:0]   PULSE_LIM  = (CW+1)'(PULSE_CYCLES);

  generate
    if (SLOT_CYCLES < 2) begin : g_bad_slot_cycles
      $error("ppm_slot_modulator: SLOT_CYCLES must be >= 2");
    end
    if (PULSE_CYCLES < 1 || PULSE_CYCLES > SLOT_CYCLES) begin : g_bad_pulse_cycles
      $error("ppm_slot_modulator: PULSE_CYCLES must be in 1..SLOT_CYCLES");
    end
    if (GUARD_SLOTS < 0 || GUARD_SLOTS > 15) begin : g_bad_guard_slots
      $error("ppm_slot_modulator: GUARD_SLOTS must be in 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {
`ifdef PPM_PREAMBLE_EN
    PREAMBLE = 2'd2,
`endif
    IDLE     = 2'd0,
    SYM      = 2'd1
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cyc_cnt, cyc_d, cyc_adv;
  logic [SW-1:0] slot_idx, slot_d, slot_adv;
  logic [1:0]    sym_q, sym_d;
  logic          accept, frame_last, last_d, in_pulse;
  logic          ppm_d, ready_d, busy_d, done_d;

  assign accept     = sym_valid & sym_ready;
  assign frame_last = (cyc_cnt == CYC_LAST) && (slot_idx == SLOT_LAST);

  // Frame position advance, wrapping both counters at the end of the frame
  always_comb begin
    cyc_adv  = cyc_cnt + CW'(1);
    slot_adv = slot_idx;
    if (cyc_cnt == CYC_LAST) begin
      cyc_adv  = '0;
      slot_adv = frame_last ? '0 : slot_idx + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cyc_cnt   <= '0;
      slot_idx  <= '0;
      sym_q     <= '0;
      ppm_out   <= 1'b0;
      sym_ready <= 1'b0;
      busy      <= 1'b0;
      sym_done  <= 1'b0;
    end else begin
      state     <= state_d;
      cyc_cnt   <= cyc_d;
      slot_idx  <= slot_d;
      sym_q     <= sym_d;
      ppm_out   <= ppm_d;
      sym_ready <= ready_d;
      busy      <= busy_d;
      sym_done  <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cyc_d   = cyc_cnt;
    slot_d  = slot_idx;
    sym_d   = sym_q;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef PPM_PREAMBLE_EN
          state_d = PREAMBLE;
`else
          state_d = SYM;
`endif
          cyc_d  = '0;
          slot_d = '0;
          sym_d  = sym_in;
        end
      end
      SYM: begin
        cyc_d  = cyc_adv;
        slot_d = slot_adv;
        if (frame_last) begin
          if (accept) begin
            state_d = SYM;
            sym_d   = sym_in;
          end else begin
            state_d = IDLE;
          end
        end
      end
`ifdef PPM_PREAMBLE_EN
      PREAMBLE: begin
        cyc_d  = cyc_adv;
        slot_d = slot_adv;
        if (frame_last) state_d = SYM;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next frame position so the registered pulse lands on frame cycle 0
  always_comb begin
    last_d   = (cyc_d == CYC_LAST) && (slot_d == SLOT_LAST);
    in_pulse = {1'b0, cyc_d} < PULSE_LIM;
    ppm_d    = 1'b0;
    ready_d  = 1'b0;
    done_d   = 1'b0;
    busy_d   = 1'b1;
    case (state_d)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      SYM: begin
        ppm_d   = in_pulse && (slot_d == SW'(sym_d));
        ready_d = last_d;
        done_d  = last_d;
      end
`ifdef PPM_PREAMBLE_EN
      PREAMBLE: begin
        ppm_d = in_pulse && ((slot_d == '0) || (slot_d == PRE_SLOT_B));
      end
`endif
      default: busy_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_ppm_slot_modulator.sv
// Scoreboarded bench for ppm_slot_modulator: accepted symbols queue expected frames, a monitor checks each on sym_done.
module tb_ppm_slot_modulator;

  localparam int SC = 4;
  localparam int PC = 2;
  localparam int GS = 1;
  localparam int F  = (4 + GS) * SC;
`ifdef PPM_PREAMBLE_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] sym_in = '0;
  logic       sym_valid = 1'b0;
  logic       sym_ready, ppm_out, busy, sym_done;

  logic [1:0] sym_in2 = '0;
  logic       sym_valid2 = 1'b0;
  logic       sym_ready2, ppm_out2, busy2, sym_done2;

  always #5 clk = ~clk;

  ppm_slot_modulator #(.SLOT_CYCLES(SC), .PULSE_CYCLES(PC), .GUARD_SLOTS(GS)) u_dut (
    .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
    .sym_ready(sym_ready), .ppm_out(ppm_out), .busy(busy), .sym_done(sym_done)
  );

  ppm_slot_modulator #(.SLOT_CYCLES(4), .PULSE_CYCLES(4), .GUARD_SLOTS(0)) u_g0 (
    .clk(clk), .rst(rst), .sym_in(sym_in2), .sym_valid(sym_valid2),
    .sym_ready(sym_ready2), .ppm_out(ppm_out2), .busy(busy2), .sym_done(sym_done2)
  );

  int tests = 0;
  int fails = 0;
  int edge_n = 0;
  int exp_sym[$];
  int exp_edge[$];
  bit exp_pre[$];
  bit ppm_h[$];
  bit busy_h[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference frames built from slot arithmetic: pulse where cycle/SC equals the pulsed slot
  function automatic logic [63:0] data_pat(input int s);
    logic [63:0] p = '0;
    for (int c = 0; c < F; c++) p[c] = ((c / SC) == s) && ((c % SC) < PC);
    return p;
  endfunction

  function automatic logic [63:0] pre_pat();
    logic [63:0] p = '0;
    for (int c = 0; c < F; c++) p[c] = (((c / SC) == 0) || ((c / SC) == 3)) && ((c % SC) < PC);
    return p;
  endfunction

  // Stimulus side of the scoreboard: every accepted symbol queues its expected frame
  always @(posedge clk) begin
    edge_n = edge_n + 1;
    if (rst === 1'b0 && sym_valid === 1'b1 && sym_ready === 1'b1) begin
      exp_sym.push_back(int'(sym_in));
      exp_edge.push_back(edge_n);
      exp_pre.push_back(PRE && (busy === 1'b0));
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      ppm_h.push_back(ppm_out);
      busy_h.push_back(busy);
      while (ppm_h.size() > 2 * F) void'(ppm_h.pop_front());
      while (busy_h.size() > 2 * F) void'(busy_h.pop_front());
      check("ready_rule", {63'd0, sym_ready}, {63'd0, (!busy) | sym_done});
      if (sym_done === 1'b1) begin
        if (exp_sym.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL done_unexpected: sym_done=1 with no symbol pending, expected 0 (t=%0t)", $time);
        end else begin
          int s, e, len, nb;
          bit p;
          logic [63:0] act;
          s = exp_sym.pop_front();
          e = exp_edge.pop_front();
          p = exp_pre.pop_front();
          len = p ? 2 * F : F;
          check("done_latency", 64'(edge_n - e), 64'(len - 1));
          if (ppm_h.size() < len) begin
            tests++;
            fails++;
            $display("FAIL history_short: got %0d cycles expected %0d", ppm_h.size(), len);
          end else begin
            act = '0;
            for (int i = 0; i < F; i++) act[i] = ppm_h[ppm_h.size() - F + i];
            check("pulse_pattern", act, data_pat(s));
            if (p) begin
              act = '0;
              for (int i = 0; i < F; i++) act[i] = ppm_h[ppm_h.size() - 2 * F + i];
              check("preamble_pattern", act, pre_pat());
            end
            nb = 0;
            for (int i = 0; i < len; i++) nb += int'(busy_h[busy_h.size() - len + i]);
            check("busy_window", 64'(nb), 64'(len));
          end
        end
      end
    end
  end

  int run2 = 0;
  int max2 = 0;
  int hi2 = 0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (ppm_out2 === 1'b1) begin
        run2++;
        hi2++;
        if (run2 > max2) max2 = run2;
      end else begin
        run2 = 0;
      end
    end
  end

  // All tasks start and end just after a falling edge
  task automatic send(input logic [1:0] s, input bit hold);
    sym_in = s;
    sym_valid = 1'b1;
    for (int n = 0; n < 4 * F; n++) begin
      if (sym_ready === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        if (!hold) sym_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL send_timeout: sym_ready stayed 0, expected 1 within %0d cycles", 4 * F);
    sym_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 4 * F; n++) begin
      if (busy === 1'b0) begin
        check("idle_ready", {63'd0, sym_ready}, 64'd1);
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL idle_timeout: busy stayed 1, expected 0 within %0d cycles", 4 * F);
  endtask

  task automatic do_reset(input int cycles);
    #1 rst = 1'b1;
    #1;
    check("rst_ppm", {63'd0, ppm_out}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, sym_done}, 64'd0);
    check("rst_ready", {63'd0, sym_ready}, 64'd0);
    exp_sym.delete();
    exp_edge.delete();
    exp_pre.delete();
    ppm_h.delete();
    busy_h.delete();
    repeat (cycles) @(negedge clk);
    #2 rst = 1'b0;
    #1 check("ready_before_edge", {63'd0, sym_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_release", {63'd0, sym_ready}, 64'd1);
  endtask

  task automatic send2(input logic [1:0] s);
    sym_in2 = s;
    sym_valid2 = 1'b1;
    for (int n = 0; n < 200; n++) begin
      if (sym_ready2 === 1'b1) begin
        @(posedge clk);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    tests++;
    fails++;
    $display("FAIL send2_timeout: sym_ready2 stayed 0, expected 1");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with a valid symbol offered
    rst = 1'b1;
    sym_valid = 1'b1;
    sym_in = 2'd2;
    repeat (3) @(negedge clk);
    check("hold_ppm", {63'd0, ppm_out}, 64'd0);
    check("hold_ready", {63'd0, sym_ready}, 64'd0);
    check("hold_busy", {63'd0, busy}, 64'd0);
    check("hold_done", {63'd0, sym_done}, 64'd0);
    sym_valid = 1'b0;
    #2 rst = 1'b0;
    #1 check("ready_before_edge", {63'd0, sym_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_release", {63'd0, sym_ready}, 64'd1);
    check("idle_busy", {63'd0, busy}, 64'd0);

    for (int s = 0; s < 4; s++) begin
      send(2'(s), 1'b0);
      wait_idle();
    end

    send(2'd3, 1'b1);
    send(2'd0, 1'b0);
    wait_idle();

    // Valid offered mid-frame must be ignored
    send(2'd1, 1'b0);
    sym_in = 2'd3;
    sym_valid = 1'b1;
    repeat (3) @(negedge clk);
    sym_valid = 1'b0;
    wait_idle();

    for (int k = 0; k < 30; k++) begin
      bit hold;
      hold = 1'($urandom_range(0, 1));
      send(2'($urandom_range(0, 3)), hold);
      if (!hold) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if ($urandom_range(0, 3) == 0) wait_idle();
      end
    end
    sym_valid = 1'b0;
    wait_idle();

    // Reset in frame cycle 5 of symbol 1, then symbol 2
    send(2'd1, 1'b0);
    repeat (5) @(negedge clk);
    check("pulse_before_reset", {63'd0, ppm_out}, 64'd1);
    do_reset(2);
    send(2'd2, 1'b0);
    wait_idle();

    // No guard slots, full-width pulses: 3 then 0 merge into one run
    send2(2'd3);
    send2(2'd0);
    sym_valid2 = 1'b0;
    repeat (60) @(negedge clk);
    check("g0_run", 64'(max2), 64'd8);
    check("g0_high_total", 64'(hi2), PRE ? 64'd16 : 64'd8);

    repeat (2) @(negedge clk);
    check("pending_symbols", 64'(exp_sym.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
